// File: rtl/fraction_divider4_pkg.sv
// Shared widths, iteration count and FSM encoding for the Q1.6 / Q1.3 fraction divider.
package fraction_div_pkg;

  localparam int DW   = 7;  // dividend width, Q1.6
  localparam int VW   = 4;  // divisor / quotient / remainder width, Q1.3
  localparam int ITER = 3;  // quotient magnitude bits produced by DIV

  // Legacy-compatible state codes; the enum below takes its values from these
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DIV  = ST_DIV,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/fraction_divider4_if.sv
// Start/Done handshake and operand/result bus of the fraction divider.
interface fraction_divider4_if;

  logic                              St;
  logic [fraction_div_pkg::DW-1:0]   Dividend;
  logic [fraction_div_pkg::VW-1:0]   Divisor;
  logic [fraction_div_pkg::VW-1:0]   Quotient;
  logic [fraction_div_pkg::VW-1:0]   Remainder;
  logic                              V;
  logic                              Done;

  modport master (output St, Dividend, Divisor, input Quotient, Remainder, V, Done);
  modport slave  (input St, Dividend, Divisor, output Quotient, Remainder, V, Done);

endinterface

// File: rtl/fraction_divider4_sign_mag.sv
// Conditional two's-complement negation: gives |x| when negate is the sign bit,
// and applies a sign to a magnitude when negate is the desired sign.
module frac_sign_mag #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Negate or pass through; negating zero yields zero, so no negative zero appears
  always_comb begin
    result = value;
    if (negate) begin
      result = ~value + W'(1);
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/fraction_divider4.sv
// Sequential sign-magnitude restoring divider: Q1.6 dividend / Q1.3 divisor,
// one quotient bit per clock, Q1.3 quotient, remainder in 2^-6 units, overflow flag.
module fraction_divider4
  import fraction_div_pkg::*;
(
  input  logic                CLK,
  input  logic                Rst,
  fraction_divider4_if.slave  bus
);

  state_e            state_r;
  logic [DW-1:0]     dividend_r;
  logic [VW-1:0]     divisor_r;
  logic [DW-1:0]     pr_r;        // partial remainder magnitude
  logic [ITER-1:0]   q_r;         // quotient magnitude, MSB first
  logic [1:0]        cnt_r;
  logic [VW-1:0]     quotient_r;
  logic [VW-1:0]     remainder_r;
  logic              v_r;

  logic [DW-1:0]     d_mag_s;
  logic [VW-1:0]     y_mag_s;
  logic [VW-1:0]     q_fix_s;
  logic [VW-1:0]     r_fix_s;
  logic              ovf_s;
  logic [DW:0]       trial_s;

  frac_sign_mag #(.W(DW)) u_abs_dividend (
    .value (dividend_r), .negate (dividend_r[DW-1]), .result (d_mag_s)
  );

  frac_sign_mag #(.W(VW)) u_abs_divisor (
    .value (divisor_r), .negate (divisor_r[VW-1]), .result (y_mag_s)
  );

  frac_sign_mag #(.W(VW)) u_sign_quotient (
    .value  ({1'b0, q_r}),
    .negate (dividend_r[DW-1] ^ divisor_r[VW-1]),
    .result (q_fix_s)
  );

  // Remainder magnitude is below |divisor| <= 8, so three bits hold it
  frac_sign_mag #(.W(VW)) u_sign_remainder (
    .value  ({1'b0, pr_r[2:0]}),
    .negate (dividend_r[DW-1]),
    .result (r_fix_s)
  );

  // Overflow when dividing by zero or when the quotient magnitude would reach 8
  always_comb begin
    ovf_s = 1'b0;
    if (y_mag_s == 4'd0) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ({1'b0, d_mag_s} >= {1'b0, y_mag_s, 3'b000});
    end
  end

  // Trial subtraction of the divisor aligned to the current quotient bit
  always_comb begin
    trial_s = {1'b0, pr_r} - ({4'd0, y_mag_s} << (2'd2 - cnt_r));
  end

  // Control FSM and datapath registers
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_r     <= IDLE;
      dividend_r  <= 7'd0;
      divisor_r   <= 4'd0;
      pr_r        <= 7'd0;
      q_r         <= 3'd0;
      cnt_r       <= 2'd0;
      quotient_r  <= 4'd0;
      remainder_r <= 4'd0;
      v_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.St) begin
            dividend_r <= bus.Dividend;
            divisor_r  <= bus.Divisor;
            state_r    <= LOAD;
          end else begin
            state_r    <= IDLE;
          end
        end
        LOAD: begin
          if (ovf_s) begin
            v_r         <= 1'b1;
            quotient_r  <= 4'd0;
            remainder_r <= 4'd0;
            state_r     <= DONE;
          end else begin
            v_r     <= 1'b0;
            pr_r    <= d_mag_s;
            q_r     <= 3'd0;
            cnt_r   <= 2'd0;
            state_r <= DIV;
          end
        end
        DIV: begin
          if (!trial_s[DW]) begin
            pr_r <= trial_s[DW-1:0];
          end
          q_r <= {q_r[ITER-2:0], ~trial_s[DW]};
          if (cnt_r == 2'(ITER - 1)) begin
            cnt_r   <= 2'd0;
            state_r <= FIX;
          end else begin
            cnt_r   <= cnt_r + 2'd1;
            state_r <= DIV;
          end
        end
        FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          state_r     <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Quotient  = quotient_r;
  assign bus.Remainder = remainder_r;
  assign bus.V         = v_r;
  assign bus.Done      = (state_r == DONE);

endmodule

// File: tb/tb_fraction_divider4.sv
// Self-checking bench for fraction_divider4: directed table, hand sequences, random vs. model.
module tb_fraction_divider4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fraction_divider4_if bus ();

  fraction_divider4 dut (
    .CLK (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] dividend;
    logic [3:0] divisor;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_v;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed fractional values
  function automatic logic [8:0] model(input logic [6:0] dd, input logic [3:0] dv);
    int a, b, d, y, q, r;
    logic [3:0] qv, rv;
    a = int'($signed(dd));
    b = int'($signed(dv));
    d = (a < 0) ? -a : a;
    y = (b < 0) ? -b : b;
    if (y == 0 || d >= 8 * y) return {1'b1, 8'h00};
    q = d / y;
    r = d % y;
    if ((a < 0) != (b < 0)) q = -q;
    if (a < 0) r = -r;
    qv = q[3:0];
    rv = r[3:0];
    return {1'b0, qv, rv};
  endfunction

  // Run one operation; optionally scramble inputs while it is in flight
  task automatic run_op(input logic [6:0] dd, input logic [3:0] dv,
                        input logic [3:0] eq, input logic [3:0] er, input logic ev,
                        input int elat, input bit scramble, input string tag);
    int lat;
    @(negedge clk);
    bus.St = 1'b1;
    bus.Dividend = dd;
    bus.Divisor = dv;
    @(posedge clk);
    #1;
    bus.St = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      if (scramble) begin
        bus.Dividend = 7'($urandom);
        bus.Divisor  = 4'($urandom);
      end
      @(posedge clk);
      #1;
      if (bus.Done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_q"}, int'(bus.Quotient), int'(eq));
    check({tag, "_r"}, int'(bus.Remainder), int'(er));
    check({tag, "_v"}, int'(bus.V), int'(ev));
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, int'(bus.Done), 0);
  endtask

  initial begin
    logic [8:0] m;
    logic [6:0] rd;
    logic [3:0] rv;
    int cnt;
    bit seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{7'b0010000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 5};
    vecs[1] = '{7'b0010101, 4'b0110, 4'b0011, 4'b0011, 1'b0, 5};
    vecs[2] = '{7'b1101011, 4'b0110, 4'b1101, 4'b1101, 1'b0, 5};
    vecs[3] = '{7'b0010000, 4'b1000, 4'b1110, 4'b0000, 1'b0, 5};
    vecs[4] = '{7'b0000000, 4'b1100, 4'b0000, 4'b0000, 1'b0, 5};
    vecs[5] = '{7'b0100000, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1};
    vecs[6] = '{7'b0010101, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};
    vecs[7] = '{7'b1000000, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1};
    vecs[8] = '{7'b0111111, 4'b1000, 4'b1001, 4'b0111, 1'b0, 5};
    vecs[9] = '{7'b0110111, 4'b0111, 4'b0111, 4'b0110, 1'b0, 5};

    bus.St = 1'b0;
    bus.Dividend = 7'd0;
    bus.Divisor = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", int'(bus.Quotient), 0);
    check("reset_r", int'(bus.Remainder), 0);
    check("reset_v", int'(bus.V), 0);
    check("reset_done", int'(bus.Done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dividend, vecs[i].divisor, vecs[i].exp_q, vecs[i].exp_r,
             vecs[i].exp_v, vecs[i].exp_lat, 1'b0, $sformatf("vec%0d", i));
    end

    // St held high: back-to-back operations 7 cycles apart
    @(negedge clk);
    bus.St = 1'b1;
    bus.Dividend = 7'b0010101;
    bus.Divisor = 4'b0110;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_first_done", int'(seen), 1);
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        cnt = k;
        break;
      end
    end
    bus.St = 1'b0;
    check("held_spacing", cnt, 7);
    check("held_q", int'(bus.Quotient), 4'b0011);
    @(posedge clk);
    #1;

    // Operand changes mid-operation must not disturb the result
    run_op(7'b1101011, 4'b0110, 4'b1101, 4'b1101, 1'b0, 5, 1'b1, "scramble");

    // Reset during DIV discards the operation
    @(negedge clk);
    bus.St = 1'b1;
    bus.Dividend = 7'b0010101;
    bus.Divisor = 4'b0110;
    @(posedge clk);
    #1;
    bus.St = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_q", int'(bus.Quotient), 0);
    check("mid_rst_r", int'(bus.Remainder), 0);
    check("mid_rst_done", int'(bus.Done), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) seen = 1'b1;
    end
    check("mid_rst_no_done", int'(seen), 0);
    run_op(7'b0010000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 5, 1'b0, "after_rst");

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      rd = 7'($urandom);
      rv = 4'($urandom);
      m = model(rd, rv);
      run_op(rd, rv, m[7:4], m[3:0], m[8], m[8] ? 1 : 5, i[0], $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
